// File: rtl/student_audio_pkg.sv
// student_audio_pkg: shared gain constants, gain FSM states and output saturation helper
package student_audio_pkg;

    localparam int GAIN_FRAC  = 14;
    localparam int GAIN_UNITY = 16384;

    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} gain_state_e;

    // Clamp a sign-extended value into the signed range of a w-bit word
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return v > hi ? hi : (v < -hi - 64'sd1 ? -hi - 64'sd1 : v);
    endfunction

endpackage

// File: rtl/student_peak_meter.sv
// student_peak_meter: magnitude peak hold with proportional decay on each sample strobe
module student_peak_meter
    import student_audio_pkg::*;
#(
    parameter int W     = 24,
    parameter int SHIFT = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic [W-1:0] sample_i,
    output logic [W-1:0] peak_o
);

    logic [W-1:0] mag, peak_q, peak_d;

    // Unsigned magnitude (most negative value maps to 2^(W-1)), then attack or decay
    always_comb begin
        mag    = sample_i[W-1] ? -sample_i : sample_i;
        peak_d = !valid_i ? peak_q : (mag > peak_q ? mag : peak_q - (peak_q >> SHIFT));
    end

    // Peak register
    always_ff @(posedge clk_i) begin
        peak_q <= rst_i ? '0 : peak_d;
    end

    assign peak_o = peak_q;

endmodule

// File: rtl/student_fir_gain_ramp.sv
// student_fir_gain_ramp: ramped digital gain with soft mute, saturation, clip flag and peak meter
module student_fir_gain_ramp
    import student_audio_pkg::*;
#(
    parameter int DATA_IN_W        = 24,
    parameter int DATA_OUT_W       = 24,
    parameter int GAIN_W           = 16,
    parameter int RAMP_STEP        = 64,
    parameter int PEAK_DECAY_SHIFT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_strobe_in,
    input  logic [DATA_IN_W-1:0]  sample_in,
    input  logic [GAIN_W-1:0]     gain_target_i,
    input  logic                  mute_i,
    input  logic                  clip_clr_i,
    output logic                  valid_strobe_out,
    output logic [DATA_OUT_W-1:0] sample_out,
    output logic [GAIN_W-1:0]     gain_cur_o,
    output logic                  ramp_busy_o,
    output logic                  clip_o,
    output logic [DATA_OUT_W-1:0] peak_o
);

    localparam int PW = DATA_IN_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

    logic [GAIN_W-1:0]     tgt, gain_q, gain_d;
    gain_state_e           state_q, state_d;
    logic                  s1_valid_q;
    logic [DATA_IN_W-1:0]  s1_sample_q;
    logic [GAIN_W-1:0]     s1_gain_q;
    logic signed [PW-1:0]  prod;
    logic signed [63:0]    shifted, sat;
    logic                  sat_hit, clip_q, clip_d, valid_q;
    logic [DATA_OUT_W-1:0] sample_q;

    // Gain moves one step toward the effective target per input strobe, clamped at the target
    always_comb begin
        tgt    = mute_i ? '0 : gain_target_i;
        gain_d = gain_q;
        if (valid_strobe_in)
            gain_d = tgt > gain_q ? (tgt - gain_q > STEP ? gain_q + STEP : tgt)
                                  : (gain_q - tgt > STEP ? gain_q - STEP : tgt);
    end

    // Next state re-evaluates direction on every strobe so a target change reverses the ramp
    always_comb begin
        state_d = state_q;
        if (valid_strobe_in)
            state_d = gain_d == tgt ? IDLE : (tgt > gain_d ? RAMP_UP : RAMP_DOWN);
    end

    // State and gain registers; gain starts at zero so audio fades in after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    // FSM outputs
    always_comb begin
        ramp_busy_o = state_q != IDLE;
        gain_cur_o  = gain_q;
    end

    // Stage 1 captures the sample with the gain in force before this strobe's update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_sample_q <= '0;
            s1_gain_q   <= '0;
        end else begin
            s1_valid_q <= valid_strobe_in;
            if (valid_strobe_in) begin
                s1_sample_q <= sample_in;
                s1_gain_q   <= gain_q;
            end
        end
    end

    // Stage 2 arithmetic: signed multiply, floor shift by the gain fraction, saturate
    always_comb begin
        prod    = $signed(s1_sample_q) * $signed({1'b0, s1_gain_q});
        shifted = 64'(prod) >>> GAIN_FRAC;
        sat     = saturate(shifted, DATA_OUT_W);
        sat_hit = s1_valid_q && (sat != shifted);
        clip_d  = sat_hit | (clip_q & ~clip_clr_i);
    end

    // Output registers; a saturation in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            sample_q <= '0;
            clip_q   <= 1'b0;
        end else begin
            valid_q <= s1_valid_q;
            clip_q  <= clip_d;
            if (s1_valid_q)
                sample_q <= sat[DATA_OUT_W-1:0];
        end
    end

    assign valid_strobe_out = valid_q;
    assign sample_out       = sample_q;
    assign clip_o           = clip_q;

    student_peak_meter #(
        .W     (DATA_OUT_W),
        .SHIFT (PEAK_DECAY_SHIFT)
    ) u_peak (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_q),
        .sample_i (sample_q),
        .peak_o   (peak_o)
    );

endmodule

// File: tb/tb_student_fir_gain_ramp.sv
// tb_student_fir_gain_ramp: directed stimulus with a queue scoreboard checked by an output monitor
module tb_student_fir_gain_ramp;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_strobe_in = 1'b0;
    logic [23:0] sample_in = '0;
    logic [15:0] gain_target_i = '0;
    logic        mute_i = 1'b0;
    logic        clip_clr_i = 1'b0;
    logic        valid_strobe_out;
    logic [23:0] sample_out;
    logic [15:0] gain_cur_o;
    logic        ramp_busy_o;
    logic        clip_o;
    logic [23:0] peak_o;

    typedef struct {
        logic [23:0] d;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   g;

    student_fir_gain_ramp dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .valid_strobe_in  (valid_strobe_in),
        .sample_in        (sample_in),
        .gain_target_i    (gain_target_i),
        .mute_i           (mute_i),
        .clip_clr_i       (clip_clr_i),
        .valid_strobe_out (valid_strobe_out),
        .sample_out       (sample_out),
        .gain_cur_o       (gain_cur_o),
        .ramp_busy_o      (ramp_busy_o),
        .clip_o           (clip_o),
        .peak_o           (peak_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every output strobe must match the oldest expectation, on its due cycle
    always @(negedge clk) begin
        if (valid_strobe_out) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out got=%h expected no strobe (cycle %0d)", sample_out, cyc);
            end else begin
                e = q.pop_front();
                if (sample_out !== e.d || cyc != e.due) begin
                    fails++;
                    $display("FAIL sample_out got=%h at cycle %0d expected=%h at cycle %0d",
                             sample_out, cyc, e.d, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle input strobe; when push is set the expected output is due two cycles later
    task automatic strobe(input logic [23:0] s, input logic push, input logic [23:0] exp);
        valid_strobe_in = 1'b1;
        sample_in       = s;
        if (push) q.push_back('{exp, cyc + 2});
        @(posedge clk);
        #1;
        valid_strobe_in = 1'b0;
    endtask

    initial begin
        wait_cyc(3);
        chk("reset_gain", gain_cur_o, 0);
        chk("reset_busy", ramp_busy_o, 0);
        chk("reset_clip", clip_o, 0);
        chk("reset_peak", peak_o, 0);
        chk("reset_sample", sample_out, 0);
        chk("reset_valid", valid_strobe_out, 0);
        rst_i = 1'b0;
        gain_target_i = 16'd16384;
        wait_cyc(1);

        // Fade-in ramp from zero to unity
        for (int k = 1; k <= 256; k++) begin
            strobe(24'h0, 1'b1, 24'h0);
            chk("ramp_up_gain", gain_cur_o, 64 * k);
            chk("ramp_up_busy", ramp_busy_o, k < 256);
        end
        wait_cyc(2);

        // Unity gain passes the sample through
        strobe(24'h100000, 1'b1, 24'h100000);
        wait_cyc(2);
        chk("unity_clip", clip_o, 0);
        chk("peak_attack", peak_o, 24'h100000);

        // Peak decay by peak>>4 per output strobe
        strobe(24'h0, 1'b1, 24'h0);
        wait_cyc(2);
        chk("peak_decay1", peak_o, 24'h0F0000);
        strobe(24'h0, 1'b1, 24'h0);
        wait_cyc(2);
        chk("peak_decay2", peak_o, 24'h0E1000);

        // Ramp to maximum gain, then saturate in both directions
        gain_target_i = 16'd32767;
        for (int i = 0; i < 300 && gain_cur_o != 16'd32767; i++) strobe(24'h0, 1'b1, 24'h0);
        chk("ramp_to_max", gain_cur_o, 32767);
        chk("max_busy", ramp_busy_o, 0);
        strobe(24'h600000, 1'b1, 24'h7FFFFF);
        strobe(24'hA00000, 1'b1, 24'h800000);
        wait_cyc(2);
        chk("clip_set", clip_o, 1);
        chk("peak_neg_full", peak_o, 24'h800000);

        // Clear coinciding with a new saturation loses; a later clear takes effect
        strobe(24'h600000, 1'b1, 24'h7FFFFF);
        clip_clr_i = 1'b1;
        wait_cyc(1);
        clip_clr_i = 1'b0;
        chk("clip_set_wins", clip_o, 1);
        wait_cyc(1);
        clip_clr_i = 1'b1;
        wait_cyc(1);
        clip_clr_i = 1'b0;
        chk("clip_cleared", clip_o, 0);

        // Back down to unity
        gain_target_i = 16'd16384;
        for (int i = 0; i < 300 && gain_cur_o != 16'd16384; i++) strobe(24'h0, 1'b1, 24'h0);
        chk("ramp_down_unity", gain_cur_o, 16384);

        // Soft mute, reversed halfway, then muted fully
        mute_i = 1'b1;
        g = 16384;
        for (int k = 1; k <= 128; k++) begin
            strobe(24'h100000, 1'b1, 24'(64 * g));
            g -= 64;
        end
        chk("mute_half_gain", gain_cur_o, 8192);
        chk("mute_half_busy", ramp_busy_o, 1);
        mute_i = 1'b0;
        strobe(24'h100000, 1'b1, 24'(64 * g));
        g += 64;
        chk("unmute_gain", gain_cur_o, 8256);
        chk("unmute_busy", ramp_busy_o, 1);
        mute_i = 1'b1;
        for (int i = 0; i < 300 && gain_cur_o != 16'd0; i++) begin
            strobe(24'h100000, 1'b1, 24'(64 * g));
            g -= 64;
        end
        chk("mute_gain_zero", gain_cur_o, 0);
        chk("mute_idle", ramp_busy_o, 0);
        strobe(24'h100000, 1'b1, 24'h0);
        strobe(24'hA00000, 1'b1, 24'h0);
        wait_cyc(3);
        chk("muted_output", sample_out, 0);

        // Reset one cycle after a strobe discards the in-flight sample
        mute_i = 1'b0;
        for (int k = 0; k < 3; k++) strobe(24'h0, 1'b1, 24'h0);
        chk("pre_reset_gain", gain_cur_o, 192);
        strobe(24'h100000, 1'b0, 24'h0);
        rst_i = 1'b1;
        wait_cyc(2);
        chk("rst_gain", gain_cur_o, 0);
        chk("rst_valid", valid_strobe_out, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_peak", peak_o, 0);
        rst_i = 1'b0;
        wait_cyc(4);
        chk("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/student_fir_gain_ramp.md
Name: student_fir_gain_ramp

Overview:
- Output-conditioning stage between the parallel FIR filter and the IIS handler.
- Consumes the FIR's signed 24-bit sample and valid strobe, applies a per-sample ramped digital gain with soft mute, and saturates the result.
- Presents a strobed sample to the IIS handler's left-channel input.
- Also provides a peak meter and a sticky clip flag for later register exposure.

Parameters:
- DATA_IN_W, 24, width of the signed FIR output sample
- DATA_OUT_W, 24, width of the signed sample delivered to the IIS handler
- GAIN_W, 16, unsigned gain width; fixed-point Q2.14, unity = 16384
- RAMP_STEP, 64, gain change per accepted input strobe
- PEAK_DECAY_SHIFT, 4, peak decays by peak>>PEAK_DECAY_SHIFT per output strobe

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- valid_strobe_in  in  1  one-cycle pulse, sample_in valid
- sample_in  in  DATA_IN_W  signed FIR output
- gain_target_i  in  GAIN_W  requested gain, Q2.14
- mute_i  in  1  level; forces effective target to 0
- clip_clr_i  in  1  pulse; clears clip_o
- valid_strobe_out  out  1  one-cycle pulse, sample_out valid
- sample_out  out  DATA_OUT_W  signed, gained, saturated sample
- gain_cur_o  out  GAIN_W  current applied gain
- ramp_busy_o  out  1  high while gain is ramping
- clip_o  out  1  sticky saturation flag
- peak_o  out  DATA_OUT_W  unsigned peak magnitude

Behaviour:
- Interface: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - all outputs 0;
  - gain_cur = 0, so audio fades in after reset;
  - FSM = IDLE; pipeline valids cleared.
- Reset mid-operation discards in-flight samples; no valid_strobe_out is produced for them.
- Effective target: tgt = mute_i ? 0 : gain_target_i, sampled on each valid_strobe_in.
- Gain FSM, evaluated only on cycles with valid_strobe_in:
  - IDLE: gain_cur==tgt. Goes to RAMP_UP if tgt>gain_cur, RAMP_DOWN if tgt<gain_cur.
  - RAMP_UP: gain_cur += RAMP_STEP, clamped to tgt. Goes to IDLE when equal; direction is re-evaluated every strobe, so a target change mid-ramp reverses.
  - RAMP_DOWN: symmetric, clamped at tgt; never below 0.
  - ramp_busy_o = (state != IDLE).
- Pipeline:
  - Latency is exactly 2 cycles; back-to-back strobes are fully supported.
  - Stage 1 registers sample_in together with the gain_cur value from before that strobe's update.
  - Stage 2 computes the product signed(sample) × signed({1'b0,gain}), width DATA_IN_W+GAIN_W+1.
  - The product is arithmetic-shifted right by 14 (truncation toward -inf) and saturated to [-2^(DATA_OUT_W-1), 2^(DATA_OUT_W-1)-1].
  - The stage-2 result is registered to sample_out; sample_out holds its value between strobes.
- Clip:
  - clip_o is set on any output strobe where saturation occurred.
  - clip_clr_i clears it.
  - If set and clear occur in the same cycle, set wins.
- Peak meter, on each valid_strobe_out:
  - a = |sample_out|, unsigned DATA_OUT_W bits; |-2^(W-1)| = 2^(W-1) fits.
  - If a > peak, peak = a; otherwise peak -= peak>>PEAK_DECAY_SHIFT.
  - Peak is held between strobes.
- With gain=0 the output is exactly 0, including for negative inputs.

Decomposition:
- Package student_audio_pkg holds:
  - GAIN_FRAC=14 and GAIN_UNITY=16384;
  - the gain FSM enum gain_state_e {IDLE, RAMP_UP, RAMP_DOWN};
  - a saturate function shared with the FIR output path.
- Sub-module student_peak_meter contains the peak register and decay logic: inputs valid strobe and sample; output peak.

Test Plan:
- Reset, gain_target_i=16384, mute_i=0, continuous strobes:
  - gain_cur_o steps 64, 128, … and reaches 16384 after 256 strobes;
  - ramp_busy_o falls on that strobe.
- At unity gain, sample_in=0x100000 → sample_out=0x100000 exactly 2 cycles later; clip_o=0.
- gain_cur=32767, sample_in=0x600000 → product>>14 = 12582528 → sample_out=0x7FFFFF, clip_o=1.
  - Then sample_in=0xA00000 (-6291456) → sample_out=0x800000; peak_o=0x800000.
- clip_o=1 with clip_clr_i pulsed in the same cycle as a new saturating strobe → clip_o stays 1. A clear on a later, non-saturating cycle → clip_o=0.
- Peak decay: peak_o=0x100000, then zero-valued strobes → 0x0F0000, then 0x0E1000.
- At unity, assert mute_i: 256 strobes ramp to 0 and sample_out is 0 thereafter.
  - Deassert mid-ramp at gain 8192 → next strobe gain 8256, state RAMP_UP.
  - rst_i asserted one cycle after a strobe → no valid_strobe_out; gain_cur_o=0.
